// File: rtl/lane_pkg.sv
// lane_pkg: shared mode enumeration and default lane constant for lane_map_shifter.
package lane_pkg;
  typedef enum logic [1:0] {MODE_CONST, MODE_PASS, MODE_ROTATE, MODE_COUNT} mode_e;
  localparam logic [127:0] CONST_LANE_DEFAULT = 128'h1234567890abcdef1234567890abcdef;
endpackage

// File: rtl/lane_rotate.sv
// lane_rotate: combinational lane rotate; output lane i takes input lane (i + shift) mod LANES.
module lane_rotate #(
  parameter int LANE_W = 128,
  parameter int LANES = 4
) (
  input  logic [LANE_W*LANES-1:0]   data,
  input  logic [$clog2(LANES)-1:0]  shift,
  output logic [LANE_W*LANES-1:0]   rotated
);
  localparam int W = LANE_W * LANES;
  assign rotated = W'({data, data} >> (32'(shift) * LANE_W));
endmodule

// File: rtl/lane_map_shifter.sv
// lane_map_shifter: one-deep registered stage that maps each accepted beat per cfg_mode.
module lane_map_shifter
  import lane_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int LANES = 4,
  parameter logic [DATA_W/LANES-1:0] CONST_LANE = (DATA_W/LANES)'(CONST_LANE_DEFAULT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                cfg_mode,
  input  logic [$clog2(LANES)-1:0]  cfg_shift,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [31:0]               beat_count
);
  localparam int LANE_W = DATA_W / LANES;
  if (DATA_W % LANES != 0 || LANES < 2 || (LANES & (LANES - 1)) != 0) begin : g_bad_params
    $fatal(1, "lane_map_shifter: DATA_W must split into a power-of-two LANES >= 2");
  end
  mode_e mode;
  logic accept;
  logic [DATA_W-1:0] const_data, count_data, rot_data, next_data;
  assign mode = mode_e'(cfg_mode);
  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign const_data = {LANES{CONST_LANE}};
  for (genvar i = 0; i < LANES; i++) begin : g_count
    assign count_data[i*LANE_W +: LANE_W] = LANE_W'({beat_count, 8'h00} | 40'(i));
  end
  lane_rotate #(.LANE_W(LANE_W), .LANES(LANES)) u_rotate (
    .data    (in_data),
    .shift   (cfg_shift),
    .rotated (rot_data)
  );
  always_comb
    next_data = mode == MODE_CONST  ? const_data :
                mode == MODE_PASS   ? in_data    :
                mode == MODE_ROTATE ? rot_data   : count_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      beat_count <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_data   <= next_data;
      beat_count <= beat_count + 32'd1;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_lane_map_shifter.sv
// tb_lane_map_shifter: randomized bench against a lane-array reference model plus directed literal checks.
module tb_lane_map_shifter;
  localparam logic [127:0] C = 128'h1234567890abcdef1234567890abcdef;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 0, preload = 0;
  logic [1:0] cfg_mode = 0, cfg_shift = 0;
  logic [511:0] in_data = '0, out_data;
  logic [31:0] beat_count;
  int checks = 0, failures = 0;
  logic m_valid;
  logic [511:0] m_data;
  logic [31:0] m_count;

  lane_map_shifter dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_shift(cfg_shift),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] expect_beat(input int mode, input int shift,
                                                input logic [511:0] d, input logic [31:0] cnt);
    logic [127:0] lin [4];
    logic [127:0] lout [4];
    logic [511:0] r;
    for (int l = 0; l < 4; l++) lin[l] = d[l*128 +: 128];
    for (int l = 0; l < 4; l++)
      case (mode)
        0: lout[l] = C;
        1: lout[l] = lin[l];
        2: lout[l] = lin[(l + shift) % 4];
        default: lout[l] = (128'(cnt) << 8) | 128'(l);
      endcase
    for (int l = 0; l < 4; l++) r[l*128 +: 128] = lout[l];
    return r;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  always @(posedge clk or posedge rst or posedge preload)
    if (rst) begin
      m_valid <= 0;
      m_data  <= '0;
      m_count <= '0;
    end else if (preload) begin
      m_count <= 32'hFFFFFFFF;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1;
      m_data  <= expect_beat(int'(cfg_mode), int'(cfg_shift), in_data, m_count);
      m_count <= m_count + 1;
    end else if (out_ready) begin
      m_valid <= 0;
    end

  always @(negedge clk) begin
    chk("in_ready", 512'(in_ready), 512'(!rst && (!m_valid || out_ready)));
    chk("out_valid", 512'(out_valid), 512'(m_valid));
    chk("beat_count", 512'(beat_count), 512'(m_count));
    if (m_valid || rst) chk("out_data", out_data, m_data);
  end

  initial begin
    logic [511:0] rot_in, a, b;
    rot_in = {{16{8'h33}}, {16{8'h22}}, {16{8'h11}}, {16{8'h00}}};
    chk("model_rotate_lane0", 512'(expect_beat(2, 1, rot_in, 0) & 512'({128{1'b1}})), 512'({16{8'h11}}));
    chk("model_count_lane2", 512'(expect_beat(3, 0, '0, 2) >> 256) & 512'({128{1'b1}}), 512'(128'h202));
    repeat (2) cyc();
    chk("reset_out_valid", 512'(out_valid), 512'(0));
    chk("reset_out_data", out_data, '0);
    rst = 0;
    #1;
    chk("in_ready_after_reset", 512'(in_ready), 512'(1));
    out_ready = 1;
    cfg_mode = 0; in_valid = 1; in_data = rand_data();
    cyc();
    in_valid = 0;
    chk("const_valid", 512'(out_valid), 512'(1));
    chk("const_data", out_data, {4{C}});
    chk("const_count", 512'(beat_count), 512'(1));
    cyc();
    cfg_mode = 2; cfg_shift = 1; in_valid = 1; in_data = rot_in;
    cyc();
    in_valid = 0;
    chk("rotate_lane0", 512'(out_data[127:0]), 512'({16{8'h11}}));
    chk("rotate_lane3", 512'(out_data[511:384]), 512'({16{8'h00}}));
    cyc();
    out_ready = 0; cfg_mode = 1; a = rand_data(); b = rand_data();
    in_valid = 1; in_data = a;
    cyc();
    in_data = b;
    repeat (5) begin
      chk("stall_in_ready", 512'(in_ready), 512'(0));
      chk("stall_hold", out_data, a);
      cfg_mode = 0;
      cyc();
    end
    cfg_mode = 1; out_ready = 1;
    cyc();
    in_valid = 0;
    chk("release_next_beat", out_data, b);
    chk("release_valid", 512'(out_valid), 512'(1));
    cyc();
    chk("drained", 512'(out_valid), 512'(0));
    rst = 1;
    cyc();
    rst = 0; cfg_mode = 3; in_valid = 1;
    repeat (3) cyc();
    in_valid = 0;
    chk("count_lane2", 512'(out_data[256 +: 128]), 512'(128'h202));
    chk("count_beats", 512'(beat_count), 512'(3));
    cyc();
    cfg_mode = 1; in_valid = 1; in_data = rand_data();
    cyc();
    in_valid = 0; out_ready = 0;
    rst = 1;
    #1;
    chk("async_rst_valid", 512'(out_valid), 512'(0));
    chk("async_rst_data", out_data, '0);
    chk("async_rst_count", 512'(beat_count), 512'(0));
    cyc();
    rst = 0; out_ready = 1;
    cyc();
    chk("no_replay", 512'(out_valid), 512'(0));
    preload = 1;
    force dut.beat_count = 32'hFFFFFFFF;
    #1;
    release dut.beat_count;
    preload = 0;
    cfg_mode = 3; in_valid = 1;
    cyc();
    in_valid = 0;
    chk("wrap_count", 512'(beat_count), 512'(0));
    chk("wrap_lane1", 512'(out_data[128 +: 128]), 512'(128'hFFFFFFFF01));
    repeat (400) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_shift = 2'($urandom_range(0, 3));
      in_data = rand_data();
      cyc();
    end
    in_valid = 0;
    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
